// File: rtl/pwm_meas.sv
// PWM waveform monitor: measures period and high time in clock cycles and
// flags stuck-high / stuck-low lines when no rising edge arrives in time.
module pwm_meas #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 2**CNT_W - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_stuck_hi,
  output logic             o_stuck_lo
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } state_t;

  state_t           state;
  logic             sync1;
  logic             s_pwm;
  logic             s_pwm_d;
  logic             rise;
  logic             p_sat;
  logic             h_sat;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] h;

  always_comb begin
    rise  = s_pwm & ~s_pwm_d;
    p_sat = (p == TMO);
    h_sat = (h == TMO);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      s_pwm   <= 1'b0;
      s_pwm_d <= 1'b0;
    end else begin
      sync1   <= i_pwm;
      s_pwm   <= sync1;
      s_pwm_d <= s_pwm;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p <= '0;
      h <= '0;
    end else if (rise) begin
      p <= CNT_W'(1);
      h <= CNT_W'(1);
    end else begin
      if (!p_sat)
        p <= p + CNT_W'(1);
      if (s_pwm && !h_sat)
        h <= h + CNT_W'(1);
    end
  end

  // The timeout branch keeps firing while p stays saturated; only the first
  // hit latches a flag, so a later fall cannot flip stuck_hi into stuck_lo.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= WAIT_FIRST;
      o_period   <= '0;
      o_high     <= '0;
      o_valid    <= 1'b0;
      o_stuck_hi <= 1'b0;
      o_stuck_lo <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (rise) begin
        if (state == MEASURE) begin
          o_period <= p;
          o_high   <= h;
          o_valid  <= 1'b1;
        end
        o_stuck_hi <= 1'b0;
        o_stuck_lo <= 1'b0;
        state      <= MEASURE;
      end else if (p_sat) begin
        if (!o_stuck_hi && !o_stuck_lo) begin
          if (s_pwm)
            o_stuck_hi <= 1'b1;
          else
            o_stuck_lo <= 1'b1;
        end
        state <= WAIT_FIRST;
      end
    end
  end

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: a 16-bit instance for measurement/reset
// scenarios and an 8-bit instance for timeout and stuck-line scenarios.
module tb_pwm_meas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16_n, rst8_n, pwm16, pwm8;
  logic [15:0] period16, high16;
  logic        valid16, shi16, slo16;
  logic [7:0]  period8, high8;
  logic        valid8, shi8, slo8;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned per;
    int unsigned hi;
  } meas_t;

  meas_t       q16[$];
  meas_t       q8[$];
  meas_t       m16, m8;
  bit          known[2];
  int unsigned prev_per[2];
  int unsigned prev_hi[2];
  int unsigned rise_cyc[2];
  bit          pv16 = 1'b0;
  bit          pv8  = 1'b0;

  pwm_meas dut16 (
    .i_clk      (clk),
    .i_rst_n    (rst16_n),
    .i_pwm      (pwm16),
    .o_period   (period16),
    .o_high     (high16),
    .o_valid    (valid16),
    .o_stuck_hi (shi16),
    .o_stuck_lo (slo16)
  );

  pwm_meas #(.CNT_W(8), .TIMEOUT(255)) dut8 (
    .i_clk      (clk),
    .i_rst_n    (rst8_n),
    .i_pwm      (pwm8),
    .o_period   (period8),
    .o_high     (high8),
    .o_valid    (valid8),
    .o_stuck_hi (shi8),
    .o_stuck_lo (slo8)
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pwm(input bit sel, input logic v);
    if (sel) pwm8 = v;
    else     pwm16 = v;
  endtask

  // Rising edge: the interval that just closed becomes an expected result.
  task automatic start_rise(input bit sel);
    if (known[sel]) begin
      if (sel) q8.push_back('{prev_per[sel], prev_hi[sel]});
      else     q16.push_back('{prev_per[sel], prev_hi[sel]});
    end
    rise_cyc[sel] = cyc;
    set_pwm(sel, 1'b1);
  endtask

  task automatic pwm_cycle(input bit sel, input int unsigned hi, input int unsigned per,
                           input bit chk_clr);
    start_rise(sel);
    for (int j = 0; j < int'(hi); j++) begin
      @(negedge clk);
      if (chk_clr && j == 2) begin
        chk("stuck_hi_cleared", sel ? shi8 : shi16, 0);
        chk("stuck_lo_cleared", sel ? slo8 : slo16, 0);
      end
    end
    set_pwm(sel, 1'b0);
    repeat (per - hi) @(negedge clk);
    known[sel]    = 1'b1;
    prev_per[sel] = per;
    prev_hi[sel]  = hi;
  endtask

  always @(negedge clk) begin
    if (valid16) begin
      chk("valid16_width", pv16, 0);
      chk("valid16_latency", (cyc - rise_cyc[0]) inside {3, 4}, 1);
      if (q16.size() == 0) chk("valid16_unexpected", valid16, 0);
      else begin
        m16 = q16.pop_front();
        chk("period16", period16, m16.per);
        chk("high16", high16, m16.hi);
        chk("high_le_period16", high16 <= period16, 1);
      end
    end
    pv16 = valid16;
    if (valid8) begin
      chk("valid8_width", pv8, 0);
      chk("valid8_latency", (cyc - rise_cyc[1]) inside {3, 4}, 1);
      if (q8.size() == 0) chk("valid8_unexpected", valid8, 0);
      else begin
        m8 = q8.pop_front();
        chk("period8", period8, m8.per);
        chk("high8", high8, m8.hi);
        chk("high_le_period8", high8 <= period8, 1);
      end
    end
    pv8 = valid8;
  end

  initial begin
    rst16_n = 1'b0;
    rst8_n  = 1'b0;
    pwm16   = 1'b0;
    pwm8    = 1'b0;
    known   = '{default: 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_period16", period16, 0);
    chk("rst_high16", high16, 0);
    chk("rst_valid16", valid16, 0);
    chk("rst_stuck16", {shi16, slo16}, 0);
    chk("rst_period8", period8, 0);
    chk("rst_stuck8", {shi8, slo8}, 0);
    rst16_n = 1'b1;

    // 100/30 stream, then 40/39, then 40/1
    for (int i = 0; i < 4; i++) pwm_cycle(0, 30, 100, 0);
    for (int i = 0; i < 3; i++) pwm_cycle(0, 39, 40, 0);
    for (int i = 0; i < 3; i++) pwm_cycle(0, 1, 40, 0);
    for (int i = 0; i < 2; i++) pwm_cycle(0, 30, 100, 0);

    // Asynchronous reset mid-period
    start_rise(0);
    repeat (30) @(negedge clk);
    pwm16 = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_period16", period16, 100);
    #2 rst16_n = 1'b0;
    #1;
    chk("async_rst_period16", period16, 0);
    chk("async_rst_high16", high16, 0);
    chk("async_rst_valid16", valid16, 0);
    chk("async_rst_stuck16", {shi16, slo16}, 0);
    known[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst16_n = 1'b1;
    for (int i = 0; i < 3; i++) pwm_cycle(0, 30, 100, 0);
    start_rise(0);
    repeat (10) @(negedge clk);
    pwm16 = 1'b0;
    repeat (10) @(negedge clk);

    // Line held low from reset
    rst8_n = 1'b1;
    repeat (255) @(negedge clk);
    chk("stuck_lo_early", slo8, 0);
    @(negedge clk);
    chk("stuck_lo_set", slo8, 1);
    chk("stuck_lo_hi_clear", shi8, 0);
    chk("stuck_lo_period8", period8, 0);
    chk("stuck_lo_high8", high8, 0);

    // Line held high after a rise
    start_rise(1);
    repeat (257) @(negedge clk);
    chk("stuck_hi_early", shi8, 0);
    chk("stuck_lo_cleared_by_rise", slo8, 0);
    @(negedge clk);
    chk("stuck_hi_set", shi8, 1);
    chk("stuck_hi_lo_clear", slo8, 0);
    pwm8 = 1'b0;
    repeat (10) @(negedge clk);
    chk("fall_keeps_stuck_hi", shi8, 1);
    chk("fall_no_stuck_lo", slo8, 0);
    known[1] = 1'b0;

    // Recovery at spacing 50, then rises exactly at TIMEOUT spacing
    pwm_cycle(1, 25, 50, 1);
    pwm_cycle(1, 100, 255, 0);
    pwm_cycle(1, 100, 255, 0);
    start_rise(1);
    repeat (10) @(negedge clk);
    pwm8 = 1'b0;
    repeat (10) @(negedge clk);
    chk("timeout_rise_no_stuck_hi", shi8, 0);
    chk("timeout_rise_no_stuck_lo", slo8, 0);

    repeat (5) @(negedge clk);
    chk("pending16", q16.size(), 0);
    chk("pending8", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_meas.md
Name: pwm_meas

Overview:
- Downstream monitor for the pwm_gen output. Measures the period and high time of the PWM waveform in i_clk cycles, and reports stuck-high (100% duty) and stuck-low (0% duty) conditions.
- Sits beside the top level on the o_pwm net. Feeds a self-check / readback path, so duty and frequency selections can be confirmed on silicon.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 2**CNT_W-1, cycles without a rising edge before a stuck condition is declared. Must be <= 2**CNT_W-1.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_pwm  input  1  PWM waveform under measurement; may be asynchronous.
- o_period  output  CNT_W  last measured period, in clocks, rising edge to rising edge.
- o_high  output  CNT_W  last measured high time, in clocks.
- o_valid  output  1  one-cycle pulse when o_period/o_high update.
- o_stuck_hi  output  1  no edge for TIMEOUT cycles while high.
- o_stuck_lo  output  1  no edge for TIMEOUT cycles while low.

Behaviour:
- Reset: asynchronous on i_rst_n low.
  - All outputs, synchronizer flops, counters and FSM go to 0 / WAIT_FIRST.
  - Reset mid-measurement discards the partial measurement; the next measurement needs two fresh rising edges.
- Input conditioning:
  - 2-flop synchronizer gives s_pwm, plus a registered s_pwm_d.
  - rise = s_pwm & ~s_pwm_d.
  - Total latency from i_pwm rising to the rise cycle: 3 clock edges.
- Period counter p:
  - On rise, p <= 1.
  - Otherwise p <= p+1, saturating at TIMEOUT.
- High counter h:
  - On rise, h <= 1.
  - Else if s_pwm, h <= h+1, saturating at TIMEOUT.
  - Else h holds.
- FSM states WAIT_FIRST and MEASURE:
  - WAIT_FIRST, on rise: go to MEASURE. o_valid stays 0, because the previous partial interval is unknown.
  - MEASURE, on rise: o_period <= p, o_high <= h, o_valid <= 1 for exactly that cycle, clear both stuck flags, stay in MEASURE.
  - MEASURE or WAIT_FIRST, with p == TIMEOUT and no rise: set o_stuck_hi if s_pwm=1, else set o_stuck_lo. Go to WAIT_FIRST.
  - o_period and o_high hold their last values in this case; o_valid is not pulsed.
  - In WAIT_FIRST, p counts from reset even before any edge has been seen. A line held low from reset therefore raises o_stuck_lo after TIMEOUT cycles.
- Stuck flags:
  - Sticky until the next rise; both clear on that rise.
  - o_stuck_hi and o_stuck_lo are never both 1.
  - If the level changes while stuck without a rising edge (a fall only), the flag is unchanged.
- Rise on the same cycle that p == TIMEOUT: rise wins. Measure normally; no stuck flag set.
- Invariant: o_high <= o_period whenever o_valid=1.
- Duty 0% or 100% from pwm_gen produces no edges, so it is reported only via the stuck flags.
- o_valid is registered: asserted the clock after the rise cycle is detected, and coincident with the new o_period/o_high.
- No combinational path from i_pwm to any output.

Test Plan:
- Reset, then square wave period 100, high 30 (CNT_W=16): no o_valid on the first rise. On each later rise: o_valid single-cycle pulse, o_period=100, o_high=30. Pulse occurs 3–4 clocks after the i_pwm rise.
- Switch mid-stream to period 40, high 40-1=39, then period 40, high 1: the first valid after the switch reports the transitional interval. Subsequent valids report 40/39, then 40/1.
- CNT_W=8, TIMEOUT=255, i_pwm held high after a rise: o_stuck_hi=1 exactly 255 cycles after the rise cycle, o_stuck_lo=0, no o_valid. Next two rises at spacing 50: stuck cleared on the first rise, valid with o_period=50 on the second.
- CNT_W=8, i_pwm held low from reset: o_stuck_lo=1 after 255 cycles. o_period/o_high remain 0.
- Assert i_rst_n=0 mid-period for 2 cycles, with o_period=100 previously: all outputs 0 immediately (asynchronous). The first rise after release gives no valid; the second gives the correct period.
- Rise forced on the exact cycle p reaches TIMEOUT (CNT_W=8, rising-edge spacing 255): o_valid=1, o_period=255, no stuck flag.
